// File: rtl/vadd_ctrl_pkg.sv
// Shared constants for the VecAdd s_axi_control responder: register map, CTRL bit
// positions, FSM state types and a byte-strobe merge helper.
package vadd_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_GIE  = 8'h04;
  localparam logic [7:0] ADDR_IER  = 8'h08;
  localparam logic [7:0] ADDR_ISR  = 8'h0C;
  localparam logic [7:0] ADDR_N_LO = 8'h10;
  localparam logic [7:0] ADDR_N_HI = 8'h14;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_DONE  = 1;
  localparam int unsigned CTRL_IDLE  = 2;
  localparam int unsigned CTRL_READY = 3;
  localparam int unsigned CTRL_AUTO  = 7;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    strb_merge = old;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) strb_merge[8*i +: 8] = data[8*i +: 8];
  endfunction

endpackage

// File: rtl/vadd_ctrl_s_axi.sv
// AXI4-Lite control slave for the VecAdd kernel: ap_start/status, scalar n, and
// (when CTRL_IRQ_EN is defined) GIE/IER/ISR with a registered level interrupt.
module vadd_ctrl_s_axi
  import vadd_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              s_axi_control_AWVALID,
  output logic              s_axi_control_AWREADY,
  input  logic [ADDR_W-1:0] s_axi_control_AWADDR,
  input  logic              s_axi_control_WVALID,
  output logic              s_axi_control_WREADY,
  input  logic [DATA_W-1:0] s_axi_control_WDATA,
  input  logic [3:0]        s_axi_control_WSTRB,
  output logic              s_axi_control_BVALID,
  input  logic              s_axi_control_BREADY,
  output logic [1:0]        s_axi_control_BRESP,
  input  logic              s_axi_control_ARVALID,
  output logic              s_axi_control_ARREADY,
  input  logic [ADDR_W-1:0] s_axi_control_ARADDR,
  output logic              s_axi_control_RVALID,
  input  logic              s_axi_control_RREADY,
  output logic [DATA_W-1:0] s_axi_control_RDATA,
  output logic [1:0]        s_axi_control_RRESP,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_ready,
  input  logic              ap_idle,
  output logic [63:0]       n,
  output logic              interrupt
);

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;
  logic              live;
  logic [ADDR_W-1:0] aw_addr;
  logic              aw_hs, w_hs, ar_hs;
  logic              wr_ctrl, wr_n_lo, wr_n_hi;
  logic              auto_restart, done_flag, ready_flag, idle_q;
  logic [DATA_W-1:0] rd_word;

`ifdef CTRL_IRQ_EN
  logic       gie, irq_q;
  logic [1:0] ier, isr, isr_next;
  logic       wr_gie, wr_ier, wr_isr;
`endif

  // live holds the ready outputs low through reset and for the first edge after it
  assign s_axi_control_AWREADY = live && (wr_state == WR_IDLE);
  assign s_axi_control_WREADY  = (wr_state == WR_DATA);
  assign s_axi_control_BVALID  = (wr_state == WR_RESP);
  assign s_axi_control_ARREADY = live && (rd_state == RD_IDLE);
  assign s_axi_control_RVALID  = (rd_state == RD_DATA);
  assign s_axi_control_BRESP   = '0;
  assign s_axi_control_RRESP   = '0;

  assign aw_hs = s_axi_control_AWVALID && s_axi_control_AWREADY;
  assign w_hs  = s_axi_control_WVALID  && s_axi_control_WREADY;
  assign ar_hs = s_axi_control_ARVALID && s_axi_control_ARREADY;

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (aw_hs) wr_next = WR_DATA;
      WR_DATA: if (w_hs) wr_next = WR_RESP;
      WR_RESP: if (s_axi_control_BREADY) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (s_axi_control_RREADY) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      live     <= 1'b0;
      aw_addr  <= '0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      live     <= 1'b1;
      if (aw_hs) aw_addr <= s_axi_control_AWADDR;
    end
  end

  assign wr_ctrl = w_hs && (aw_addr == ADDR_CTRL[ADDR_W-1:0]);
  assign wr_n_lo = w_hs && (aw_addr == ADDR_N_LO[ADDR_W-1:0]);
  assign wr_n_hi = w_hs && (aw_addr == ADDR_N_HI[ADDR_W-1:0]);

  // Status flags: a kernel pulse outranks the clear-on-read so no event is lost
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      done_flag    <= 1'b0;
      ready_flag   <= 1'b0;
      idle_q       <= 1'b0;
      n            <= '0;
    end else begin
      idle_q <= ap_idle;
      if (wr_ctrl && s_axi_control_WSTRB[0] && s_axi_control_WDATA[CTRL_START])
        ap_start <= 1'b1;
      else if (ap_ready && !auto_restart)
        ap_start <= 1'b0;
      if (wr_ctrl && s_axi_control_WSTRB[0])
        auto_restart <= s_axi_control_WDATA[CTRL_AUTO];
      if (ap_done)
        done_flag <= 1'b1;
      else if (ar_hs && s_axi_control_ARADDR == ADDR_CTRL[ADDR_W-1:0])
        done_flag <= 1'b0;
      if (ap_ready)
        ready_flag <= 1'b1;
      else if (ar_hs && s_axi_control_ARADDR == ADDR_CTRL[ADDR_W-1:0])
        ready_flag <= 1'b0;
      if (wr_n_lo) n[31:0]  <= strb_merge(n[31:0],  s_axi_control_WDATA, s_axi_control_WSTRB);
      if (wr_n_hi) n[63:32] <= strb_merge(n[63:32], s_axi_control_WDATA, s_axi_control_WSTRB);
    end
  end

`ifdef CTRL_IRQ_EN
  assign wr_gie = w_hs && (aw_addr == ADDR_GIE[ADDR_W-1:0]) && s_axi_control_WSTRB[0];
  assign wr_ier = w_hs && (aw_addr == ADDR_IER[ADDR_W-1:0]) && s_axi_control_WSTRB[0];
  assign wr_isr = w_hs && (aw_addr == ADDR_ISR[ADDR_W-1:0]) && s_axi_control_WSTRB[0];

  always_comb begin
    isr_next = isr;
    if (wr_isr) isr_next = isr ^ s_axi_control_WDATA[1:0];
    if (ap_done  && ier[0]) isr_next[0] = 1'b1;
    if (ap_ready && ier[1]) isr_next[1] = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      gie   <= 1'b0;
      ier   <= '0;
      isr   <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_gie) gie <= s_axi_control_WDATA[0];
      if (wr_ier) ier <= s_axi_control_WDATA[1:0];
      isr   <= isr_next;
      irq_q <= gie && (|isr);
    end
  end

  assign interrupt = irq_q;
`else
  assign interrupt = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (s_axi_control_ARADDR)
      ADDR_CTRL[ADDR_W-1:0]: begin
        rd_word[CTRL_START] = ap_start;
        rd_word[CTRL_DONE]  = done_flag;
        rd_word[CTRL_IDLE]  = idle_q;
        rd_word[CTRL_READY] = ready_flag;
        rd_word[CTRL_AUTO]  = auto_restart;
      end
      ADDR_N_LO[ADDR_W-1:0]: rd_word = n[31:0];
      ADDR_N_HI[ADDR_W-1:0]: rd_word = n[63:32];
`ifdef CTRL_IRQ_EN
      ADDR_GIE[ADDR_W-1:0]:  rd_word[0]   = gie;
      ADDR_IER[ADDR_W-1:0]:  rd_word[1:0] = ier;
      ADDR_ISR[ADDR_W-1:0]:  rd_word[1:0] = isr;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst)     s_axi_control_RDATA <= '0;
    else if (ar_hs) s_axi_control_RDATA <= rd_word;
  end

endmodule
